counter_rr_scheduler: RTL and testbench

- Shares one up-counter timer between NUM_REQ requesters.
- Each requester asks for a delay of a programmed length. The scheduler grants one requester at a time, round-robin, and counts the interval.
- It pulses that requester's done when the interval completes.
- Sits between request sources (e.g. protocol engines needing wait states) and the shared counting datapath.

---
 rtl/counter_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_counter_rr_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler that lends one shared up-counter to NUM_REQ requesters.
// It counts each grantee's programmed interval and pulses that requester's done.
module counter_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         count,
  output logic [IDX_W-1:0]               owner
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [IDX_W-1:0]       ptr;
  logic [COUNT_WIDTH-1:0] len_q;

  logic                   pick_vld;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       pick_next;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [COUNT_WIDTH-1:0] pick_len;

  // Arbiter: first set request scanning upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    int pick_i;
    int n;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    pick_vld = 1'b0;
    pick     = '0;
    pick_oh  = '0;
    pick_i   = 0;
    j        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld   = 1'b1;
        pick_i     = j;
        pick       = IDX_W'(j);
        pick_oh[j] = 1'b1;
      end
    end
    pick_len = req_len[pick_i*COUNT_WIDTH +: COUNT_WIDTH];
    n = pick_i + 1;
    if (n >= NUM_REQ) n = 0;
    pick_next = IDX_W'(n);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. DONE lasts two cycles: the first holds the terminal count,
  // the second carries the done pulse, so done lands L+1 edges after grant.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (pick_vld) next_state = (pick_len == '0) ? DONE : RUN;
      RUN: begin
        if (!req[owner])                              next_state = IDLE;
        else if (count == len_q - COUNT_WIDTH'(1))    next_state = DONE;
      end
      DONE: if (|done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      done  <= '0;
      count <= '0;
      owner <= '0;
      ptr   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_oh;
            owner <= pick;
            len_q <= pick_len;
            count <= '0;
            ptr   <= pick_next;
          end
        end
        RUN: begin
          if (next_state == IDLE) begin
            grant <= '0;
            count <= '0;
          end else if (next_state == RUN) begin
            count <= count + COUNT_WIDTH'(1);
          end
        end
        DONE: begin
          if (|done) begin
            grant <= '0;
            done  <= '0;
            count <= '0;
          end else begin
            done <= grant;
          end
        end
        default: begin
          grant <= '0;
          done  <= '0;
          count <= '0;
        end
      endcase
    end
  end

  // Output logic: busy follows the registered state.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler: reset, single request, round-robin,
// zero length, abort and maximum length with hand-computed expectations.
module tb_counter_rr_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int COUNT_WIDTH = 8;

  logic                           clk;
  logic                           rst;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*COUNT_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;
  logic [COUNT_WIDTH-1:0]         count;
  logic [1:0]                     owner;

  int n_checks = 0;
  int n_pass   = 0;

  counter_rr_scheduler #(.NUM_REQ(NUM_REQ), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .count   (count),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [COUNT_WIDTH-1:0] len);
    req_len[idx*COUNT_WIDTH +: COUNT_WIDTH] = len;
  endtask

  initial begin
    int bad;
    logic [3:0] exp_oh;

    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_done",  done,  0);
    check("rst_busy",  busy,  0);
    check("rst_count", count, 0);
    check("rst_owner", owner, 0);
    rst = 1'b0;
    tick();

    // Single request, len 5: grant after E, done after E+6, grant low after E+7.
    req = 4'b0010;
    set_len(1, 8'd5);
    tick();
    check("single_grant", grant, 4'b0010);
    check("single_owner", owner, 1);
    check("single_busy",  busy,  1);
    check("single_c0",    count, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("single_count", count, k);
    end
    tick();
    check("single_hold", count, 4);
    check("single_nodone", done, 0);
    tick();
    check("single_done", done, 4'b0010);
    check("single_grant_dn", grant, 4'b0010);
    req = '0;
    tick();
    check("single_grant_off", grant, 0);
    check("single_done_off",  done,  0);
    check("single_busy_off",  busy,  0);
    check("single_count_off", count, 0);

    // Reset mid-RUN: ptr is 2, so requester 2 is granted; reset at count 3.
    req = 4'b0100;
    set_len(2, 8'd10);
    tick();
    check("mid_grant", grant, 4'b0100);
    tick();
    tick();
    tick();
    check("mid_count3", count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy",  busy,  0);
    check("mid_rst_owner", owner, 0);
    req = '0;
    tick();
    rst = 1'b0;

    // Round-robin, all four held with len 2: order 0,1,2,3,0, done 5 cycles apart.
    req_len = {4{8'd2}};
    req     = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      check("rr_grant", grant, exp_oh);
      check("rr_owner", owner, i % 4);
      tick();
      tick();
      tick();
      check("rr_done", done, exp_oh);
      if (i == 4) req = '0;
      tick();
      check("rr_gap", grant, 0);
      tick();
    end
    check("rr_idle", grant, 0);

    // Zero length on requester 3 (ptr is 1).
    req = 4'b1000;
    set_len(3, 8'd0);
    tick();
    check("zero_grant", grant, 4'b1000);
    check("zero_done0", done,  0);
    check("zero_busy",  busy,  1);
    tick();
    check("zero_done",  done,  4'b1000);
    check("zero_count", count, 0);
    req = '0;
    tick();
    check("zero_grant_off", grant, 0);
    check("zero_done_off",  done,  0);

    // Abort: requester 2 len 10 dropped at count 4, pending requester 3 next.
    req = 4'b0100;
    set_len(2, 8'd10);
    tick();
    check("abort_grant", grant, 4'b0100);
    req = 4'b1100;
    set_len(3, 8'd3);
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (done != 0) bad++;
    end
    check("abort_count4", count, 4);
    req = 4'b1000;
    tick();
    check("abort_grant_off", grant, 0);
    check("abort_count_off", count, 0);
    if (done != 0) bad++;
    check("abort_no_done", bad, 0);
    tick();
    check("abort_next", grant, 4'b1000);
    check("abort_next_own", owner, 3);
    req = '0;
    tick();
    check("abort2_off", grant, 0);

    // Max length 255, length changed after grant must not matter.
    req = 4'b0001;
    set_len(0, 8'd255);
    tick();
    check("max_grant", grant, 4'b0001);
    check("max_c0", count, 0);
    set_len(0, 8'd3);
    bad = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (count != 8'(k) || done != 0 || grant != 4'b0001) bad++;
    end
    check("max_seq_bad", bad, 0);
    tick();
    check("max_hold", count, 254);
    check("max_nodone", done, 0);
    tick();
    check("max_done", done, 4'b0001);
    check("max_done_cnt", count, 254);
    req = '0;
    tick();
    check("max_grant_off", grant, 0);
    check("max_count_off", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
